// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Stall/flush control for the 5-stage pipeline. It detects load-use hazards
//   between the instruction in ID and a load in EX, and it detects taken
//   branches resolved in EX. It drives the ID control-zeroing flush, the IF/ID
//   flush and write enables, and the PC write enable. A small FSM stretches
//   stalls and flushes over several cycles. Two saturating counters record the
//   number of hazard events.
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     ifid_rs, ifid_rt           source fields of the instruction in ID
//     ifid_uses_rt               ID instruction reads rt
//     idex_mem_read, idex_rt     EX instruction is a load, and its destination
//     ex_br_taken                branch in EX resolved taken
//     cnt_clr                    synchronous clear of both counters
//     flush                      zero the ID-stage controls
//     ifid_flush                 IF/ID loads a NOP
//     pc_write, ifid_write       PC and IF/ID register enables
//     stall_cnt, flush_cnt       saturating counts of load-use hazards and taken branches
module hazard_control_unit #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             ex_br_taken,
    input  logic             cnt_clr,
    output logic             flush,
    output logic             ifid_flush,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu_haz;
    logic             stall_inc;
    logic             flush_inc;

    // A load writing r0 never creates a real dependency.
    assign lu_haz = idex_mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        flush      = 1'b0;
        ifid_flush = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;

        if (ex_br_taken) begin
            // A taken branch overrides any stall or flush in progress and
            // restarts the flush window. The PC still loads the branch target.
            flush      = 1'b1;
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                rem_d   = 8'(FLUSH_CYCLES - 1);
            end else begin
                state_d = RUN;
                rem_d   = 8'd0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (lu_haz) begin
                        flush      = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        stall_inc  = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = STALL;
                            rem_d   = 8'(STALL_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    // A hazard seen during the stall is the same hazard.
                    // It is not counted a second time.
                    flush      = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    if (rem_q == 8'd1) begin
                        state_d = RUN;
                        rem_d   = 8'd0;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                FLUSH: begin
                    flush      = 1'b1;
                    ifid_flush = 1'b1;
                    if (rem_q == 8'd1) begin
                        state_d = RUN;
                        rem_d   = 8'd0;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 8'd0;
                end
            endcase
        end

        // While reset is held, freeze the front end and squash ID.
        if (!rst_n) begin
            flush      = 1'b1;
            ifid_flush = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    // The clear has priority over an increment. The counters stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            rem_q       <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
//   Two instances share one set of inputs.
//     dut_a: STALL_CYCLES=1, FLUSH_CYCLES=1, CNT_W=16
//     dut_b: STALL_CYCLES=3, FLUSH_CYCLES=2, CNT_W=2
//   Inputs change 1 time unit after each rising edge. Outputs are sampled on
//   the falling edge.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        ifid_uses_rt, idex_mem_read, ex_br_taken, cnt_clr;

    logic        a_flush, a_ifid_flush, a_pc_write, a_ifid_write;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_flush, b_ifid_flush, b_pc_write, b_ifid_write;
    logic [1:0]  b_stall_cnt, b_flush_cnt;

    hazard_control_unit #(.STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ex_br_taken(ex_br_taken), .cnt_clr(cnt_clr),
        .flush(a_flush), .ifid_flush(a_ifid_flush), .pc_write(a_pc_write),
        .ifid_write(a_ifid_write), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_control_unit #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ex_br_taken(ex_br_taken), .cnt_clr(cnt_clr),
        .flush(b_flush), .ifid_flush(b_ifid_flush), .pc_write(b_pc_write),
        .ifid_write(b_ifid_write), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the penalty cycles still owed, and the event counts per instance.
    int m_sl[2];
    int m_fl[2];
    int m_sc[2];
    int m_fc[2];

    function automatic int sc_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction
    function automatic int fc_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic int max_of(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction
    function automatic bit lu_model();
        return idex_mem_read && (idex_rt != 0) &&
               ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sl[i] = 0; m_fl[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    // Compare both instances against the model. Output order is {flush, ifid_flush, pc_write, ifid_write}.
    task automatic cyc_check();
        logic [3:0] exp_ctl, act_ctl;
        logic [31:0] act_sc, act_fc;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n)                          exp_ctl = 4'b1100;
            else if (ex_br_taken || m_fl[i] > 0) exp_ctl = 4'b1111;
            else if (m_sl[i] > 0 || lu_model())  exp_ctl = 4'b1000;
            else                                 exp_ctl = 4'b0011;
            if (i == 0) begin
                act_ctl = {a_flush, a_ifid_flush, a_pc_write, a_ifid_write};
                act_sc  = 32'(a_stall_cnt);
                act_fc  = 32'(a_flush_cnt);
            end else begin
                act_ctl = {b_flush, b_ifid_flush, b_pc_write, b_ifid_write};
                act_sc  = 32'(b_stall_cnt);
                act_fc  = 32'(b_flush_cnt);
            end
            check($sformatf("model_ctl_dut%0d", i), 32'(act_ctl), 32'(exp_ctl));
            check($sformatf("model_stall_cnt_dut%0d", i), act_sc, 32'(m_sc[i]));
            check($sformatf("model_flush_cnt_dut%0d", i), act_fc, 32'(m_fc[i]));
        end
    endtask

    // Advance the model by one clock edge. The inputs are still stable here.
    task automatic adv();
        bit si, fi;
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                si = 1'b0; fi = 1'b0;
                if (ex_br_taken) begin
                    m_fl[i] = fc_of(i) - 1; m_sl[i] = 0; fi = 1'b1;
                end else if (m_fl[i] > 0) begin
                    m_fl[i]--;
                end else if (m_sl[i] > 0) begin
                    m_sl[i]--;
                end else if (lu_model()) begin
                    m_sl[i] = sc_of(i) - 1; si = 1'b1;
                end
                if (cnt_clr) begin
                    m_sc[i] = 0; m_fc[i] = 0;
                end else begin
                    if (si && m_sc[i] < max_of(i)) m_sc[i]++;
                    if (fi && m_fc[i] < max_of(i)) m_fc[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic u,
                          input logic mr, input logic [4:0] xrt, input logic br, input logic clr);
        ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = u; idex_mem_read = mr;
        idex_rt = xrt; ex_br_taken = br; cnt_clr = clr;
    endtask

    task automatic idle();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        cyc_check();
        check("rst_pc_write", 32'(a_pc_write), 32'd0);
        check("rst_ifid_flush", 32'(b_ifid_flush), 32'd1);
        check("rst_stall_cnt", 32'(a_stall_cnt), 32'd0);
        #2 rst_n = 1'b1;
        adv();
    endtask

    typedef struct {
        logic [4:0]  rs, rt;
        logic        uses, mr;
        logic [4:0]  xrt;
        logic        br, clr;
        logic [3:0]  exp_ctl;
        logic [15:0] exp_sc, exp_fc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Expected values for dut_a, starting from a fresh reset. Counter values are read before the edge.
        tbl[0]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 4'b0011, 16'd0, 16'd0};
        tbl[1]  = '{5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 4'b1000, 16'd0, 16'd0};
        tbl[2]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 4'b0011, 16'd1, 16'd0};
        tbl[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'b0011, 16'd1, 16'd0};
        tbl[4]  = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 4'b1000, 16'd1, 16'd0};
        tbl[5]  = '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 4'b0011, 16'd2, 16'd0};
        tbl[6]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 4'b1111, 16'd2, 16'd0};
        tbl[7]  = '{5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 4'b1111, 16'd2, 16'd1};
        tbl[8]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 4'b0011, 16'd2, 16'd2};
        tbl[9]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 4'b1111, 16'd2, 16'd2};
        tbl[10] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 4'b0011, 16'd0, 16'd0};

        rst_n = 1'b0;
        do_reset();

        for (int k = 0; k < 11; k++) begin
            set_in(tbl[k].rs, tbl[k].rt, tbl[k].uses, tbl[k].mr, tbl[k].xrt, tbl[k].br, tbl[k].clr);
            cyc_check();
            check($sformatf("tbl%0d_ctl", k),
                  32'({a_flush, a_ifid_flush, a_pc_write, a_ifid_write}), 32'(tbl[k].exp_ctl));
            check($sformatf("tbl%0d_stall_cnt", k), 32'(a_stall_cnt), 32'(tbl[k].exp_sc));
            check($sformatf("tbl%0d_flush_cnt", k), 32'(a_flush_cnt), 32'(tbl[k].exp_fc));
            adv();
        end

        // Load-use hazard on rt with STALL_CYCLES=3 gives exactly three stall cycles.
        do_reset();
        set_in(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        cyc_check(); check("b_stall_c0_pc", 32'(b_pc_write), 32'd0); adv();
        idle();
        cyc_check(); check("b_stall_c1_pc", 32'(b_pc_write), 32'd0); adv();
        cyc_check(); check("b_stall_c2_ifidw", 32'(b_ifid_write), 32'd0); adv();
        cyc_check(); check("b_stall_done_pc", 32'(b_pc_write), 32'd1);
        check("b_stall_cnt_1", 32'(b_stall_cnt), 32'd1); adv();
        set_in(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        cyc_check(); check("b_no_rt_use_pc", 32'(b_pc_write), 32'd1); adv();

        // Branch pulse with FLUSH_CYCLES=2.
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        cyc_check(); check("b_br_c0_ifid_flush", 32'(b_ifid_flush), 32'd1); adv();
        idle();
        cyc_check(); check("b_br_c1_ifid_flush", 32'(b_ifid_flush), 32'd1);
        check("b_br_c1_pc", 32'(b_pc_write), 32'd1); adv();
        cyc_check(); check("b_br_done_flush", 32'(b_flush), 32'd0);
        check("b_flush_cnt_1", 32'(b_flush_cnt), 32'd1); adv();

        // A branch together with a load-use hazard: the branch wins and no stall is counted.
        set_in(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
        cyc_check(); check("b_br_lu_pc", 32'(b_pc_write), 32'd1); adv();
        idle();
        cyc_check(); check("b_br_lu_stall_cnt", 32'(b_stall_cnt), 32'd1); adv();

        // A branch arriving during a stall aborts the stall.
        set_in(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        cyc_check(); adv();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        cyc_check(); check("b_abort_pc", 32'(b_pc_write), 32'd1);
        check("b_abort_ifid_flush", 32'(b_ifid_flush), 32'd1); adv();
        idle();
        cyc_check(); check("b_abort_flush_win", 32'(b_ifid_flush), 32'd1); adv();
        cyc_check(); check("b_abort_run_pc", 32'(b_pc_write), 32'd1);
        check("b_abort_run_flush", 32'(b_flush), 32'd0); adv();

        // Counter saturation, then a clear that arrives together with a branch.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
            cyc_check(); adv();
        end
        idle();
        cyc_check(); check("b_flush_cnt_sat", 32'(b_flush_cnt), 32'd3);
        check("a_flush_cnt_5", 32'(a_flush_cnt), 32'd5); adv();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
        cyc_check(); adv();
        idle();
        cyc_check(); check("b_clr_wins", 32'(b_flush_cnt), 32'd0); adv();

        // Reset pulse in the middle of a flush window.
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        cyc_check(); adv();
        idle();
        rst_n = 1'b0;
        model_reset();
        cyc_check(); check("b_midflush_rst_pc", 32'(b_pc_write), 32'd0);
        #2 rst_n = 1'b1;
        adv();
        cyc_check(); check("b_after_rst_flush", 32'(b_flush), 32'd0);
        check("b_after_rst_pc", 32'(b_pc_write), 32'd1); adv();

        // Random traffic. Small register numbers make hazards frequent.
        for (int k = 0; k < 400; k++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 30) == 0));
            cyc_check();
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
